// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } irq_state_e;

  localparam int unsigned DefVecBase   = 32'hF0;
  localparam int unsigned DefVecStride = 4;

  // A single channel still needs a one-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the last hit, the lowest index, is kept.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: latches sources, masks, arbitrates and
// issues one non-nesting request to jump control, saving the return PC.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned VEC_BASE   = DefVecBase,
  parameter int unsigned VEC_STRIDE = DefVecStride,
  parameter int unsigned EDGE_MODE  = 1,
  localparam int unsigned ID_W      = id_width(NUM_IRQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic                  mask_wr,
  input  logic [NUM_IRQ-1:0]    mask_wdata,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  stall,
  input  logic                  int_ack,
  input  logic                  reti,
  output logic                  int_req,
  output logic [ADDR_WIDTH-1:0] int_vec,
  output logic [ID_W-1:0]       int_id,
  output logic                  in_service,
  output logic [ADDR_WIDTH-1:0] ret_addr,
  output logic [NUM_IRQ-1:0]    pending_q,
  output logic [NUM_IRQ-1:0]    mask_q
);

  irq_state_e            state;
  logic [NUM_IRQ-1:0]    irq_d;
  logic [NUM_IRQ-1:0]    set_vec;
  logic [NUM_IRQ-1:0]    clr_vec;
  logic [NUM_IRQ-1:0]    eligible;
  logic                  win_valid;
  logic [ID_W-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0] win_vec;

  assign set_vec  = (EDGE_MODE != 0) ? (irq_in & ~irq_d) : irq_in;
  assign clr_vec  = (state == StReq && int_ack) ? (NUM_IRQ'(1) << int_id) : '0;
  assign eligible = pending_q & mask_q;
  assign win_vec  = ADDR_WIDTH'(VEC_BASE + 32'(win_idx) * VEC_STRIDE);

  irq_prio_enc #(
    .WIDTH (NUM_IRQ),
    .IDX_W (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // A set on the channel being acknowledged beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      irq_d     <= irq_in;
      pending_q <= (pending_q & ~clr_vec) | set_vec;
      if (mask_wr) mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
      int_vec    <= ADDR_WIDTH'(VEC_BASE);
      ret_addr   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (win_valid && !stall) begin
            state   <= StReq;
            int_req <= 1'b1;
            int_id  <= win_idx;
            int_vec <= win_vec;
          end
        end
        StReq: begin
          if (int_ack) begin
            state      <= StService;
            int_req    <= 1'b0;
            in_service <= 1'b1;
            ret_addr   <= pc_in;
          end
        end
        StService: begin
          if (reti) begin
            state      <= StIdle;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= StIdle;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised vectored interrupt controller; replaces the single-wire interrupt input to the jump-control stage.
- Latches N interrupt sources, applies a mask and fixed priority, and issues one vectored request to jump control. It saves the return address and blocks nesting until a return-from-interrupt.
- Sits between external interrupt pins and jump control. Samples the current PC from the PC/IM stage.

Parameters:
- NUM_IRQ, 4, number of interrupt channels (1..16).
- ADDR_WIDTH, 8, program-address width.
- VEC_BASE, 8'hF0, address of the channel-0 handler.
- VEC_STRIDE, 4, address spacing between handler vectors.
- EDGE_MODE, 1, 1 = rising-edge sources, 0 = level sources.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw interrupt lines, already synchronous to clk.
- mask_wr  in  1  load mask register this cycle.
- mask_wdata  in  NUM_IRQ  new mask; 1 = enabled.
- pc_in  in  ADDR_WIDTH  current fetch address from PC/IM.
- stall  in  1  pipeline stall; no new request is raised while high.
- int_ack  in  1  jump control has taken the redirect.
- reti  in  1  decoded return-from-interrupt, one-cycle pulse.
- int_req  out  1  interrupt request to jump control.
- int_vec  out  ADDR_WIDTH  handler address for the request.
- int_id  out  ID_W  channel being requested or serviced; ID_W = max(1, clog2(NUM_IRQ)).
- in_service  out  1  a handler is executing.
- ret_addr  out  ADDR_WIDTH  saved return PC.
- pending_q  out  NUM_IRQ  pending register, for debug.
- mask_q  out  NUM_IRQ  mask register.

Behaviour:
- Reset (synchronous, active-high), applied on a clk edge with reset=1:
  - pending, mask, edge history, int_id and ret_addr go to 0.
  - State goes to IDLE; int_req=0, in_service=0, int_vec=VEC_BASE.
  - Reset wins over every concurrent event, including mid-REQ and mid-SERVICE.
- Source capture:
  - EDGE_MODE=1: pending[i] sets on irq_in[i] & ~irq_d[i], where irq_d is the one-cycle delayed irq_in.
  - EDGE_MODE=0: pending[i] sets whenever irq_in[i]=1.
  - Pending bits are captured in every state, including SERVICE.
- Pending clear: pending[int_id] clears on the int_ack cycle. A set event on the same channel in the same cycle wins, so the bit stays 1.
- Mask: written on mask_wr; the new value is visible from the next cycle. Masked pending bits are retained, not cleared.
- Eligible set: eligible = pending & mask. Priority is fixed: lowest index wins.
- State machine, IDLE / REQ / SERVICE:
  - IDLE: if eligible != 0 and stall=0, go to REQ next cycle. In that cycle latch int_id = winning index and int_vec = VEC_BASE + int_id*VEC_STRIDE, truncated modulo 2^ADDR_WIDTH. Latency from irq edge to int_req is 2 cycles (edge detect, then arbitrate).
  - REQ: int_req=1. int_id and int_vec are frozen: a later higher-priority arrival or a mask change does not retarget the request. On int_ack, latch ret_addr = pc_in, clear pending[int_id], go to SERVICE.
  - SERVICE: int_req=0, in_service=1. On reti go to IDLE; in_service falls the next cycle. ret_addr holds until the next ack.
- reti in IDLE or REQ is ignored. int_ack outside REQ is ignored.
- stall only gates the IDLE to REQ transition. It does not withdraw a request already raised.
- int_ack and reti in the same cycle: only the one valid for the current state acts.

Decomposition:
- Shared package irq_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2);
  - the ID_W derivation function;
  - default VEC_BASE and VEC_STRIDE constants.
- One sub-module is natural: irq_prio_enc, a parametrised lowest-index-first encoder producing a valid flag and an index from the eligible vector.

Test Plan:
- Reset with irq_in=4'b1111 held → pending_q=0, int_req=0, int_vec=8'hF0 during reset and on the cycle after release.
- mask=4'b1111, pulse irq_in[2] → int_req high 2 cycles later, int_id=2, int_vec=8'hF8. Ack with pc_in=8'h37 → in_service=1, ret_addr=8'h37, pending_q[2]=0.
- irq_in[3] and irq_in[1] rise in the same cycle → int_id=1, int_vec=8'hF4. After reti, irq 3 is served next with int_vec=8'hFC.
- mask=4'b0000, pulse irq_in[0] → no int_req, pending_q=4'b0001. Then write mask=4'b0001 → int_req rises, int_vec=8'hF0.
- While in SERVICE, pulse irq_in[0] → no request until reti. Then int_req asserts, with a 2-cycle gap after reti.
- EDGE_MODE=0, hold irq_in[1] high through ack → pending re-sets; new request after reti. stall=1 in IDLE keeps int_req=0 until stall falls.
